select_arb: RTL and testbench

SELECT_ARB -- requirements
Module: select_arb

---
 rtl/select_pkg.sv | 47 ++++
 rtl/select_arb.sv | 167 ++++++++++++++++
 tb/tb_select_arb.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/select_pkg.sv
// ---------------------------------------------------------------------------
// select_pkg
// Shared definitions for the two-requester select arbiter and the downstream
// 2:1 select stage that consumes its cntrl output.
//   - FSM state encodings (IDLE / OWN1 / OWN2)
//   - select-control values (SEL_IN1 / SEL_IN2)
//   - "last served" pointer encodings
//   - small helpers mapping an owner state to its peer and to its select value
// ---------------------------------------------------------------------------
package select_pkg;

  // Arbiter FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN1 = 2'd1;
  localparam logic [1:0] ST_OWN2 = 2'd2;

  // Downstream 2:1 select control values
  localparam logic SEL_IN1 = 1'b0;
  localparam logic SEL_IN2 = 1'b1;

  // "last served" pointer: which requester most recently gave up a grant
  localparam logic LAST_REQ1 = 1'b0;
  localparam logic LAST_REQ2 = 1'b1;

  // Peer owner state of an OWNx state (IDLE maps to IDLE).
  function automatic logic [1:0] other_owner(input logic [1:0] st);
    logic [1:0] res;
    case (st)
      ST_OWN1: res = ST_OWN2;
      ST_OWN2: res = ST_OWN1;
      default: res = ST_IDLE;
    endcase
    return res;
  endfunction

  // Pointer value recorded when leaving an OWNx state.
  function automatic logic last_for_owner(input logic [1:0] st);
    logic res;
    if (st == ST_OWN2) begin
      res = LAST_REQ2;
    end else begin
      res = LAST_REQ1;
    end
    return res;
  endfunction

endpackage : select_pkg

// File: rtl/select_arb.sv
// ---------------------------------------------------------------------------
// select_arb
// Two-requester arbiter that drives the control of a downstream 2:1 select.
// A grant, once issued, is held for at least HOLD_MIN cycles; a contested
// grant is forcibly handed over after MAX_HOLD cycles. Handover between
// requesters is direct (no IDLE bubble) when the other side is waiting.
//
// Parameters
//   HOLD_MIN  minimum owned cycles before done / dropped request is honoured
//   MAX_HOLD  owned cycles after which a contested grant is moved
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   req1   in   requester 1 wants select input in1
//   req2   in   requester 2 wants select input in2
//   done   in   current owner releases its grant
//   gnt1   out  registered grant to requester 1
//   gnt2   out  registered grant to requester 2
//   cntrl  out  registered select control (0 = in1, 1 = in2)
//   sw     out  registered one-cycle pulse when cntrl changed
// ---------------------------------------------------------------------------
module select_arb
  import select_pkg::*;
#(
  parameter int HOLD_MIN = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req1,
  input  logic req2,
  input  logic done,
  output logic gnt1,
  output logic gnt2,
  output logic cntrl,
  output logic sw
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_MIN_C = CW'(HOLD_MIN);
  localparam logic [CW-1:0] MAX_HOLD_C = CW'(MAX_HOLD);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  logic [1:0]    state;
  logic [1:0]    next_state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          last;
  logic          last_next;
  logic          cntrl_next;

  logic          own_req;
  logic          other_req;
  logic          eligible;
  logic          at_max;

  // Requests seen from the current owner's point of view, plus hold status.
  always_comb begin
    own_req   = 1'b0;
    other_req = 1'b0;
    case (state)
      ST_OWN1: begin
        own_req   = req1;
        other_req = req2;
      end
      ST_OWN2: begin
        own_req   = req2;
        other_req = req1;
      end
      default: begin
        own_req   = 1'b0;
        other_req = 1'b0;
      end
    endcase
    eligible = (cnt >= HOLD_MIN_C);
    at_max   = (cnt >= MAX_HOLD_C);
  end

  // Next-state, hold counter and last-served pointer.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    last_next  = last;
    case (state)
      ST_IDLE: begin
        // done is meaningless without an owner and is not looked at here.
        if (req1 && req2) begin
          next_state = (last == LAST_REQ2) ? ST_OWN1 : ST_OWN2;
        end else if (req1) begin
          next_state = ST_OWN1;
        end else if (req2) begin
          next_state = ST_OWN2;
        end else begin
          next_state = ST_IDLE;
        end
        if (next_state != ST_IDLE) begin
          cnt_next = CNT_ONE;
        end else begin
          cnt_next = '0;
        end
      end
      ST_OWN1, ST_OWN2: begin
        if (at_max && other_req) begin
          // Contested for too long: hand over regardless of done/own request.
          next_state = other_owner(state);
          cnt_next   = CNT_ONE;
          last_next  = last_for_owner(state);
        end else if (eligible && (done || !own_req)) begin
          last_next = last_for_owner(state);
          if (other_req) begin
            next_state = other_owner(state);
            cnt_next   = CNT_ONE;
          end else begin
            // Also covers done with own request still high: one IDLE cycle
            // before the owner can be regranted.
            next_state = ST_IDLE;
            cnt_next   = '0;
          end
        end else begin
          next_state = state;
          if (at_max) begin
            cnt_next = cnt;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end
      end
      default: begin
        next_state = ST_IDLE;
        cnt_next   = '0;
        last_next  = last;
      end
    endcase
  end

  // Select control follows the owner and holds its value through IDLE.
  always_comb begin
    cntrl_next = cntrl;
    case (next_state)
      ST_OWN1: cntrl_next = SEL_IN1;
      ST_OWN2: cntrl_next = SEL_IN2;
      default: cntrl_next = cntrl;
    endcase
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      last  <= LAST_REQ2;
      gnt1  <= 1'b0;
      gnt2  <= 1'b0;
      cntrl <= SEL_IN1;
      sw    <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      last  <= last_next;
      gnt1  <= (next_state == ST_OWN1);
      gnt2  <= (next_state == ST_OWN2);
      cntrl <= cntrl_next;
      sw    <= (cntrl_next != cntrl);
    end
  end

endmodule : select_arb

// File: tb/tb_select_arb.sv
// ---------------------------------------------------------------------------
// tb_select_arb
// Scoreboard bench for select_arb (HOLD_MIN = 2, MAX_HOLD = 4). A stimulus
// process drives inputs on the falling edge, advances a behavioural model of
// the arbitration rules and queues the expected outputs; a monitor compares
// DUT outputs shortly after each rising edge.
// ---------------------------------------------------------------------------
module tb_select_arb;

  localparam int HMIN = 2;
  localparam int HMAX = 4;

  logic clk;
  logic rst_n;
  logic req1;
  logic req2;
  logic done;
  logic gnt1;
  logic gnt2;
  logic cntrl;
  logic sw;

  typedef struct packed {
    logic g1;
    logic g2;
    logic c;
    logic s;
  } exp_t;

  exp_t exp_q[$];

  int checks;
  int errors;
  bit stim_done;

  // Behavioural model: who owns the path, for how many cycles, who was last.
  int m_owner;  // 0 = nobody, 1 = requester 1, 2 = requester 2
  int m_held;   // cycles the current owner has held the grant
  int m_last;   // requester that most recently gave up a grant
  bit m_sel;    // select value presented downstream

  select_arb #(.HOLD_MIN(HMIN), .MAX_HOLD(HMAX)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req1 (req1),
    .req2 (req2),
    .done (done),
    .gnt1 (gnt1),
    .gnt2 (gnt2),
    .cntrl(cntrl),
    .sw   (sw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_edge(input bit r, input bit r1, input bit r2, input bit d);
    bit mine;
    bit theirs;
    bit old_sel;
    exp_t e;
    old_sel = m_sel;
    if (!r) begin
      m_owner = 0;
      m_held  = 0;
      m_last  = 2;
      m_sel   = 1'b0;
      e = '{g1: 1'b0, g2: 1'b0, c: 1'b0, s: 1'b0};
      exp_q.push_back(e);
      return;
    end
    if (m_owner == 0) begin
      if (r1 && r2)  m_owner = (m_last == 2) ? 1 : 2;
      else if (r1)   m_owner = 1;
      else if (r2)   m_owner = 2;
      m_held = (m_owner != 0) ? 1 : 0;
    end else begin
      mine   = (m_owner == 1) ? r1 : r2;
      theirs = (m_owner == 1) ? r2 : r1;
      if ((m_held >= HMAX && theirs) || (m_held >= HMIN && (d || !mine))) begin
        m_last  = m_owner;
        m_owner = theirs ? (3 - m_owner) : 0;
        m_held  = theirs ? 1 : 0;
      end else begin
        m_held = m_held + 1;
      end
    end
    if (m_owner == 1) m_sel = 1'b0;
    if (m_owner == 2) m_sel = 1'b1;
    e.g1 = (m_owner == 1);
    e.g2 = (m_owner == 2);
    e.c  = m_sel;
    e.s  = (m_sel != old_sel);
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs; optionally glitch rst_n low between edges.
  task automatic step(input bit r, input bit r1, input bit r2, input bit d, input bit glitch);
    @(negedge clk);
    rst_n = r;
    req1  = r1;
    req2  = r2;
    done  = d;
    model_edge(r, r1, r2, d);
    if (glitch && r) begin
      #1 rst_n = 1'b0;
      #1 rst_n = 1'b1;
    end
  endtask

  task automatic cmp(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Monitor: compare DUT outputs against the queued expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("gnt1", gnt1, e.g1);
        cmp("gnt2", gnt2, e.g2);
        cmp("cntrl", cntrl, e.c);
        cmp("sw", sw, e.s);
        checks++;
        if (gnt1 && gnt2) begin
          errors++;
          $display("FAIL both_grants at %0t: gnt1=%b gnt2=%b", $time, gnt1, gnt2);
        end
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized traffic.
  initial begin
    int wait_cycles;
    checks = 0;
    errors = 0;
    stim_done = 1'b0;
    rst_n = 1'b0;
    req1 = 1'b0;
    req2 = 1'b0;
    done = 1'b0;

    // Reset, then a lone req1.
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);

    // Tie from reset; done in first grant cycle ignored, honoured in second.
    step(0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 1, 0);
    step(1, 1, 1, 1, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Both held with done low: forced alternation every MAX_HOLD cycles.
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 1, 1, 0, 0);

    // One-cycle req2 pulse: grant held HOLD_MIN cycles, cntrl stays 1.
    step(0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);

    // Reset at an edge during OWN2, then a between-edge glitch.
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 1);
    step(1, 0, 1, 0, 1);
    step(1, 0, 1, 0, 0);

    // done with own request high and no competitor: one IDLE then regrant.
    step(0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 1, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 1, 0);
    step(1, 1, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(63) != 0),
           ($urandom_range(3) != 0),
           ($urandom_range(2) != 0),
           ($urandom_range(2) == 0),
           ($urandom_range(15) == 0));
    end
    step(1, 0, 0, 0, 0);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    stim_done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_select_arb
